// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the MEM-stage data-memory access unit: word type,
// FSM state encoding and the alignment helper used to qualify accesses.
package dmem_access_unit_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // A word access is legal only when the two byte-offset bits are zero.
  function automatic logic is_word_aligned(input word_t addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_access_unit.sv
// MEM-stage initiator for a variable-latency req/ack data-memory bus.
// Holds the upstream pipeline while an access is outstanding, bubbles
// MEM/WB, presents load data in DONE and flags misalignment and timeouts.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16  // WAIT cycles without ack before abort; 0 disables
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] MemRDM,
  output logic        StallM,
  output logic        BubbleW,
  output logic        AdErrM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  word_t            addr_q, addr_d;
  word_t            wdata_q, wdata_d;
  word_t            data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mem_op;
  logic             acc;

  // Qualify the MEM-stage instruction: only aligned loads/stores reach the bus.
  assign mem_op = MemReadM | MemWriteM;
  assign acc    = mem_op & is_word_aligned(ALUResM);
  assign AdErrM = mem_op & ~acc;

  // State register: FSM, bus request registers, captured data, error and counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: launch in IDLE, wait for ack or timeout, retire in DONE.
  always_comb begin
    // NOTE: every target gets a hold default first so no path through the
    // case can leave one unassigned and infer a latch.
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = {ALUResM[31:2], 2'b00};
          wdata_d = WriteDataM;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_ack) begin
          // Ack has priority over a coincident timeout.
          data_d  = we_q ? '0 : mem_rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if ((TIMEOUT != 0) && (cnt_d == CNT_TO)) begin
            data_d  = '0;
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: stall/bubble while launching or waiting; result only in DONE.
  always_comb begin
    StallM  = ((state_q == S_IDLE) & acc) | (state_q == S_WAIT);
    BubbleW = StallM;
    MemRDM  = (state_q == S_DONE) ? data_q : '0;
    BusErrM = (state_q == S_DONE) & err_q;
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit (TIMEOUT=4). The driver pushes the
// expected bus request and completion of each access; a negedge monitor pops
// and compares whenever the DUT raises mem_req, retires an access, or leaves reset.
module tb_dmem_access_unit;

  localparam int TO = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_rec_t;

  typedef struct {
    logic        abort;   // 1: reset recovery, all outputs zero
    logic [31:0] rdm;
    logic        err;
    int          stall;
  } done_rec_t;

  logic        clk;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResM, WriteDataM;
  logic [31:0] MemRDM;
  logic        StallM, BubbleW, AdErrM, BusErrM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  req_rec_t  exp_req[$];
  done_rec_t exp_done[$];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_access_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUResM    (ALUResM),
    .WriteDataM (WriteDataM),
    .MemRDM     (MemRDM),
    .StallM     (StallM),
    .BubbleW    (BubbleW),
    .AdErrM     (AdErrM),
    .BusErrM    (BusErrM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ALUResM    = '0;
    WriteDataM = '0;
  endtask

  // One aligned access starting in IDLE. ack_at = WAIT cycle carrying the ack
  // (0 = never). Returns just after the edge into IDLE with inputs cleared.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_at,
                        input logic [31:0] rdata, input int exp_stall,
                        input logic [31:0] exp_rdm, input logic exp_err,
                        input logic stray_ack);
    req_rec_t  rq;
    done_rec_t dn;
    rq.we = wr; rq.addr = addr; rq.wdata = wdata;
    dn.abort = 1'b0; dn.rdm = exp_rdm; dn.err = exp_err; dn.stall = exp_stall;
    exp_req.push_back(rq);
    exp_done.push_back(dn);
    MemReadM = rd; MemWriteM = wr; ALUResM = addr; WriteDataM = wdata;
    cyc();                                  // now in WAIT 1
    for (int w = 1; w <= TO; w++) begin
      if (w == ack_at) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      cyc();
      mem_ack = 1'b0;
      mem_rdata = '0;
      if (w == ack_at) break;
    end                                     // now in DONE
    if (stray_ack) begin
      mem_ack = 1'b1;
      mem_rdata = 32'h5555_5555;
      cyc();                                // IDLE, ack still high
      clear_inputs();
      cyc();
      mem_ack = 1'b0;
      mem_rdata = '0;
    end else begin
      cyc();
      clear_inputs();
    end
  endtask

  task automatic misaligned(input logic rd, input logic wr, input logic [31:0] addr);
    MemReadM = rd; MemWriteM = wr; ALUResM = addr; WriteDataM = 32'hA5A5_A5A5;
    cyc();
    clear_inputs();
    cyc();
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    logic     prev_req;
    logic     prev_rst;
    int       stall_run;
    req_rec_t cur;
    done_rec_t d;
    logic     exp_ad;
    prev_req = 1'b0;
    prev_rst = 1'b0;
    stall_run = 0;
    cur.we = 1'b0; cur.addr = '0; cur.wdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_rst = 1'b1;
        prev_req = mem_req;
        continue;
      end
      if (prev_rst) begin
        prev_rst = 1'b0;
        check("abort_pending", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          check("abort_kind", 32'(d.abort), 32'd1);
        end
        check("rst_mem_req",   32'(mem_req), 32'd0);
        check("rst_mem_we",    32'(mem_we),  32'd0);
        check("rst_mem_addr",  mem_addr,     32'd0);
        check("rst_mem_wdata", mem_wdata,    32'd0);
        check("rst_stall",     32'(StallM),  32'd0);
        check("rst_bubble",    32'(BubbleW), 32'd0);
        check("rst_memrdm",    MemRDM,       32'd0);
        check("rst_buserr",    32'(BusErrM), 32'd0);
        check("rst_aderr",     32'(AdErrM),  32'd0);
        stall_run = 0;
        prev_req = mem_req;
        continue;
      end

      exp_ad = (MemReadM | MemWriteM) & (ALUResM[1:0] != 2'b00);
      check("bubble_eq_stall", 32'(BubbleW), 32'(StallM));
      check("aderr", 32'(AdErrM), 32'(exp_ad));
      if (exp_ad) check("aderr_no_stall", 32'(StallM), 32'd0);

      if (!prev_req && mem_req) begin
        check("req_pending", 32'(exp_req.size() != 0), 32'd1);
        if (exp_req.size() != 0) cur = exp_req.pop_front();
      end
      if (mem_req) begin
        check("mem_we",    32'(mem_we), 32'(cur.we));
        check("mem_addr",  mem_addr,    cur.addr);
        check("mem_wdata", mem_wdata,   cur.wdata);
      end

      if (prev_req && !mem_req) begin
        check("done_pending", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          check("done_kind",   32'(d.abort),   32'd0);
          check("done_memrdm", MemRDM,         d.rdm);
          check("done_buserr", 32'(BusErrM),   32'(d.err));
          check("done_stall",  32'(StallM),    32'd0);
          check("stall_len",   32'(stall_run), 32'(d.stall));
        end
        stall_run = 0;
      end else begin
        check("idle_memrdm", MemRDM,       32'd0);
        check("idle_buserr", 32'(BusErrM), 32'd0);
        if (StallM) stall_run++;
      end
      prev_req = mem_req;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver.
  initial begin
    done_rec_t ab;
    req_rec_t  rq;
    ab.abort = 1'b1; ab.rdm = '0; ab.err = 1'b0; ab.stall = 0;
    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    clear_inputs();
    exp_done.push_back(ab);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc();

    // lw 0x100, ack in 3rd WAIT cycle: 4 stall cycles.
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0BAD_F00D, 3, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cyc();
    // sw 0x204, ack in 1st WAIT: 2 stall cycles, rdata ignored for writes.
    access(1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 1, 32'hFFFF_FFFF, 2, 32'h0, 1'b0, 1'b0);
    cyc();
    // Misaligned load and store: no request, no stall.
    misaligned(1'b1, 1'b0, 32'h0000_0103);
    misaligned(1'b0, 1'b1, 32'h0000_0202);
    // Timeout after 4 WAIT cycles, then a stray ack that must be ignored.
    access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 0, 32'h0, 5, 32'h0, 1'b1, 1'b1);
    cyc();
    // Ack coincides with the timeout cycle: ack wins, no bus error.
    access(1'b1, 1'b0, 32'h0000_03FC, 32'h0, 4, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 1'b0, 1'b0);
    // Back-to-back loads with ack in 1st WAIT.
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h1111_1111, 2, 32'h1111_1111, 1'b0, 1'b0);
    access(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1, 32'h2222_2222, 2, 32'h2222_2222, 1'b0, 1'b0);
    cyc();

    // Reset asserted during the 2nd WAIT cycle of a load.
    rq.we = 1'b0; rq.addr = 32'h0000_0400; rq.wdata = 32'h0;
    exp_req.push_back(rq);
    exp_done.push_back(ab);
    MemReadM = 1'b1; ALUResM = 32'h0000_0400;
    cyc();                 // WAIT 1
    cyc();                 // WAIT 2
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    clear_inputs();
    cyc();

    // Recovery: normal load, ack in 2nd WAIT.
    access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 2, 32'h0F0F_0F0F, 3, 32'h0F0F_0F0F, 1'b0, 1'b0);
    repeat (3) cyc();

    check("req_queue_empty",  32'(exp_req.size()),  32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
